// File: rtl/imem_loader_if.sv
// Byte-stream input and imem write port shared by the loader and its neighbours.
// slave: the loader (consumes bytes, drives imem); master: the byte source / observer.
interface imem_loader_if #(
  parameter int ADDR_WIDTH = 12
);
  logic [7:0]            rx_data;
  logic                  rx_valid;
  logic                  rx_ready;
  logic [ADDR_WIDTH-1:0] imem_address;
  logic [31:0]           imem_data;
  logic                  imem_wren;

  modport slave (
    input  rx_data, rx_valid,
    output rx_ready, imem_address, imem_data, imem_wren
  );

  modport master (
    output rx_data, rx_valid,
    input  rx_ready, imem_address, imem_data, imem_wren
  );
endinterface

// File: rtl/imem_loader.sv
// Fills imem from a framed byte stream (A5, LEN_HI, LEN_LO, 4*N big-endian bytes, XOR checksum).
// Write pulse one cycle after a word's 4th byte; rx_ready drops only during that write cycle.
module imem_loader #(
  parameter int          ADDR_WIDTH = 12,
  parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
  parameter int          TIMEOUT    = 65535
) (
  input  logic                clock,
  input  logic                reset,
  imem_loader_if.slave        bus,
  output logic                cpu_reset,
  output logic                done,
  output logic                error,
  output logic [ADDR_WIDTH:0] words_loaded
);

  localparam int          TMO_W     = $clog2(TIMEOUT + 1);
  localparam logic [16:0] MAX_WORDS = 17'(2 ** ADDR_WIDTH);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_WRITE, S_CHECK, S_DONE, S_ERROR
  } state_t;

  state_t                state_q, state_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [31:0]           data_q, data_d;
  logic [ADDR_WIDTH:0]   words_q, words_d;
  logic [15:0]           len_q, len_d;
  logic [7:0]            csum_q, csum_d;
  logic [1:0]            idx_q, idx_d;
  logic [TMO_W-1:0]      tmo_q, tmo_d;
  logic                  cpu_reset_q, cpu_reset_d;
  logic                  done_q, done_d;
  logic                  error_q, error_d;

  logic        rx_ready;
  logic        acc;
  logic        in_frame;
  logic [15:0] n_words;

  assign rx_ready = (state_q != S_WRITE);
  assign acc      = bus.rx_valid && rx_ready;
  assign in_frame = (state_q == S_LEN_HI) || (state_q == S_LEN_LO) ||
                    (state_q == S_DATA)   || (state_q == S_CHECK);
  assign n_words  = {len_q[15:8], bus.rx_data};

  always_comb begin
    state_d     = state_q;
    addr_d      = addr_q;
    data_d      = data_q;
    words_d     = words_q;
    len_d       = len_q;
    csum_d      = csum_q;
    idx_d       = idx_q;
    tmo_d       = tmo_q;
    cpu_reset_d = cpu_reset_q;
    done_d      = done_q;
    error_d     = error_q;

    if (in_frame) begin
      tmo_d = acc ? '0 : tmo_q + 1'b1;
    end

    case (state_q)
      S_IDLE, S_DONE, S_ERROR: begin
        if (acc && bus.rx_data == SYNC_BYTE) begin
          state_d     = S_LEN_HI;
          addr_d      = '0;
          words_d     = '0;
          csum_d      = '0;
          idx_d       = '0;
          tmo_d       = '0;
          cpu_reset_d = 1'b1;
          done_d      = 1'b0;
          error_d     = 1'b0;
        end
      end
      S_LEN_HI: begin
        if (acc) begin
          len_d[15:8] = bus.rx_data;
          state_d     = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (acc) begin
          len_d = n_words;
          if (n_words == 16'd0) begin
            state_d = S_CHECK;
          end else if ({1'b0, n_words} > MAX_WORDS) begin
            state_d = S_ERROR;
            error_d = 1'b1;
          end else begin
            state_d = S_DATA;
          end
        end
      end
      S_DATA: begin
        if (acc) begin
          case (idx_q)
            2'd0:    data_d[31:24] = bus.rx_data;
            2'd1:    data_d[23:16] = bus.rx_data;
            2'd2:    data_d[15:8]  = bus.rx_data;
            default: data_d[7:0]   = bus.rx_data;
          endcase
          csum_d = csum_q ^ bus.rx_data;
          idx_d  = idx_q + 2'd1;
          if (idx_q == 2'd3) state_d = S_WRITE;
        end
      end
      S_WRITE: begin
        addr_d  = addr_q + 1'b1;
        words_d = words_q + 1'b1;
        state_d = (17'(words_d) == {1'b0, len_q}) ? S_CHECK : S_DATA;
      end
      S_CHECK: begin
        if (acc) begin
          if (bus.rx_data == csum_q) begin
            state_d     = S_DONE;
            done_d      = 1'b1;
            cpu_reset_d = 1'b0;
          end else begin
            state_d     = S_ERROR;
            error_d     = 1'b1;
            cpu_reset_d = 1'b1;
          end
        end
      end
      default: state_d = S_IDLE;
    endcase

    // A stalled sender overrides whatever the frame logic decided.
    if (in_frame && !acc && tmo_d == TMO_W'(TIMEOUT)) begin
      state_d     = S_ERROR;
      error_d     = 1'b1;
      cpu_reset_d = 1'b1;
      tmo_d       = '0;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      addr_q      <= '0;
      data_q      <= '0;
      words_q     <= '0;
      len_q       <= '0;
      csum_q      <= '0;
      idx_q       <= '0;
      tmo_q       <= '0;
      cpu_reset_q <= 1'b1;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      addr_q      <= addr_d;
      data_q      <= data_d;
      words_q     <= words_d;
      len_q       <= len_d;
      csum_q      <= csum_d;
      idx_q       <= idx_d;
      tmo_q       <= tmo_d;
      cpu_reset_q <= cpu_reset_d;
      done_q      <= done_d;
      error_q     <= error_d;
    end
  end

  assign bus.rx_ready     = rx_ready;
  assign bus.imem_address = addr_q;
  assign bus.imem_data    = data_q;
  assign bus.imem_wren    = (state_q == S_WRITE);
  assign cpu_reset        = cpu_reset_q;
  assign done             = done_q;
  assign error            = error_q;
  assign words_loaded     = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Scoreboarded bench for imem_loader: expected writes and frame outcomes are queued
// from a frame-level model; a monitor compares them as the DUT produces them.
module tb_imem_loader;
  localparam int AW = 12;

  logic          clock = 1'b0;
  logic          reset;
  logic          cpu_reset, done, error;
  logic [AW:0]   words_loaded;

  imem_loader_if #(.ADDR_WIDTH(AW)) bus ();

  imem_loader #(.ADDR_WIDTH(AW)) dut (
    .clock        (clock),
    .reset        (reset),
    .bus          (bus),
    .cpu_reset    (cpu_reset),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [31:0]   data;
  } wr_t;

  typedef struct packed {
    logic        done;
    logic        error;
    logic        cpu_reset;
    logic [AW:0] words;
  } st_t;

  wr_t         wr_q[$];
  st_t         st_q[$];
  logic [31:0] frame_words[$];
  int          checks = 0;
  int          errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every write pulse and every rising done/error is matched against the queues.
  initial begin
    logic prev_end = 1'b0;
    logic cur_end;
    wr_t  w;
    st_t  s;
    forever begin
      @(negedge clock);
      if (bus.imem_wren) begin
        check("rx_ready_in_write", 64'(bus.rx_ready), 64'd0);
        if (wr_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: got addr=0x%0h data=0x%0h, required no write",
                   bus.imem_address, bus.imem_data);
        end else begin
          w = wr_q.pop_front();
          check("write_addr", 64'(bus.imem_address), 64'(w.addr));
          check("write_data", 64'(bus.imem_data), 64'(w.data));
        end
      end
      cur_end = done | error;
      if (cur_end && !prev_end) begin
        if (st_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_status: got done=%0d error=%0d, required no frame end", done, error);
        end else begin
          s = st_q.pop_front();
          check("status_done", 64'(done), 64'(s.done));
          check("status_error", 64'(error), 64'(s.error));
          check("status_cpu_reset", 64'(cpu_reset), 64'(s.cpu_reset));
          check("status_words", 64'(words_loaded), 64'(s.words));
        end
      end
      prev_end = cur_end;
    end
  end

  task automatic send_byte(input logic [7:0] b);
    int wait_cnt = 0;
    repeat ($urandom_range(0, 2)) @(negedge clock);
    bus.rx_valid = 1'b1;
    bus.rx_data  = b;
    while (!bus.rx_ready) begin
      @(negedge clock);
      wait_cnt++;
      if (wait_cnt > 20) begin
        checks++;
        errors++;
        $display("FAIL rx_ready_stuck: got rx_ready=0 for %0d cycles, required at most 20", wait_cnt);
        break;
      end
    end
    @(negedge clock);
    bus.rx_valid = 1'b0;
  endtask

  // Frame-level model: word i lands at address i; outcome follows from the checksum byte sent.
  task automatic run_frame(input bit bad_sum);
    logic [7:0]  cs = 8'h00;
    logic [15:0] n  = 16'(frame_words.size());
    logic [31:0] w;
    for (int i = 0; i < frame_words.size(); i++) begin
      w = frame_words[i];
      wr_q.push_back('{addr: AW'(i), data: w});
      cs = cs ^ w[31:24] ^ w[23:16] ^ w[15:8] ^ w[7:0];
    end
    st_q.push_back('{done: !bad_sum, error: bad_sum, cpu_reset: bad_sum, words: (AW+1)'(n)});
    send_byte(8'hA5);
    send_byte(n[15:8]);
    send_byte(n[7:0]);
    for (int i = 0; i < frame_words.size(); i++) begin
      w = frame_words[i];
      send_byte(w[31:24]);
      send_byte(w[23:16]);
      send_byte(w[15:8]);
      send_byte(w[7:0]);
    end
    send_byte(bad_sum ? (cs ^ 8'h01) : cs);
    repeat (3) @(negedge clock);
  endtask

  task automatic load_t1();
    frame_words.delete();
    frame_words.push_back(32'h11223344);
    frame_words.push_back(32'h55667788);
  endtask

  initial begin
    #(10 * 90000);
    $display("FAIL watchdog: got simulation still running, required completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    reset        = 1'b1;
    bus.rx_valid = 1'b0;
    bus.rx_data  = 8'h00;
    repeat (3) @(negedge clock);
    reset = 1'b0;
    check("rst_cpu_reset", 64'(cpu_reset), 64'd1);
    check("rst_done", 64'(done), 64'd0);
    check("rst_error", 64'(error), 64'd0);
    check("rst_wren", 64'(bus.imem_wren), 64'd0);
    check("rst_addr", 64'(bus.imem_address), 64'd0);
    check("rst_data", 64'(bus.imem_data), 64'd0);
    check("rst_words", 64'(words_loaded), 64'd0);
    check("rst_rx_ready", 64'(bus.rx_ready), 64'd1);

    // T1 good frame, T2 bad checksum 0x89
    load_t1();
    run_frame(1'b0);
    run_frame(1'b1);

    // T3 leading junk ignored
    send_byte(8'h00);
    send_byte(8'hFF);
    send_byte(8'h5A);
    load_t1();
    run_frame(1'b0);

    // T4 empty image, then oversize length 0x1001
    frame_words.delete();
    run_frame(1'b0);
    st_q.push_back('{done: 1'b0, error: 1'b1, cpu_reset: 1'b1, words: '0});
    send_byte(8'hA5);
    send_byte(8'h10);
    send_byte(8'h01);
    repeat (5) @(negedge clock);
    check("oversize_error", 64'(error), 64'd1);

    // T5 stall after 0x22 until timeout, then a fresh good frame
    st_q.push_back('{done: 1'b0, error: 1'b1, cpu_reset: 1'b1, words: '0});
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    repeat (65540) @(negedge clock);
    check("timeout_error", 64'(error), 64'd1);
    check("timeout_cpu_reset", 64'(cpu_reset), 64'd1);
    load_t1();
    run_frame(1'b0);

    // T6 reset after 0x55: first word already written, the rest must be ignored
    wr_q.push_back('{addr: '0, data: 32'h11223344});
    send_byte(8'hA5);
    send_byte(8'h00);
    send_byte(8'h02);
    send_byte(8'h11);
    send_byte(8'h22);
    send_byte(8'h33);
    send_byte(8'h44);
    send_byte(8'h55);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    check("t6_wren", 64'(bus.imem_wren), 64'd0);
    check("t6_cpu_reset", 64'(cpu_reset), 64'd1);
    check("t6_addr", 64'(bus.imem_address), 64'd0);
    check("t6_words", 64'(words_loaded), 64'd0);
    send_byte(8'h66);
    send_byte(8'h77);
    send_byte(8'h88);
    send_byte(8'h88);
    repeat (5) @(negedge clock);
    check("t6_done", 64'(done), 64'd0);
    check("t6_error", 64'(error), 64'd0);
    check("t6_words_after", 64'(words_loaded), 64'd0);

    // Randomized frames with occasional corrupted checksums and stray bytes between them
    for (int f = 0; f < 8; f++) begin
      frame_words.delete();
      for (int i = 0; i < $urandom_range(1, 6); i++) frame_words.push_back($urandom);
      if ($urandom_range(0, 1) == 1) send_byte(8'h3C);
      run_frame($urandom_range(0, 3) == 0);
    end

    repeat (10) @(negedge clock);
    check("writes_outstanding", 64'(wr_q.size()), 64'd0);
    check("status_outstanding", 64'(st_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
